// File: rtl/aes_stream_adapter.sv
// aes_stream_adapter: packs stream words into an AES block, runs the cipher and streams the ciphertext back out
module aes_stream_adapter #(
  parameter int WORD_WIDTH     = 32,
  parameter int DATA_WIDTH     = 128,
  parameter int CIPHER_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] key_in,
  input  logic                  key_load,
  input  logic [WORD_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] pt_out,
  output logic [DATA_WIDTH-1:0] key_out,
  output logic                  start_out,
  input  logic [DATA_WIDTH-1:0] ct_in,
  input  logic                  done_in,
  output logic [WORD_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  timeout_err
);
  localparam int WORDS = DATA_WIDTH / WORD_WIDTH;
  localparam int CW = WORDS > 1 ? $clog2(WORDS) : 1;
  localparam int TW = $clog2(CIPHER_TIMEOUT + 1);
  typedef enum logic [1:0] {S_FILL, S_START, S_WAIT, S_DRAIN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0] pt_q, pt_d, key_q, key_d, ct_q, ct_d;
  logic err_q, err_d;
  logic accept, mhs, last, tmo_hit;
  assign accept  = state_q == S_FILL && s_valid;
  assign mhs     = state_q == S_DRAIN && m_ready;
  assign last    = cnt_q == CW'(WORDS - 1);
  assign tmo_hit = state_q == S_WAIT && !done_in && tmo_q == TW'(CIPHER_TIMEOUT - 1);
  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FILL;
    else state_q <= state_d;
  end
  // next-state logic; done beats a coinciding timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL:  state_d = accept && last ? S_START : S_FILL;
      S_START: state_d = S_WAIT;
      S_WAIT:  state_d = done_in ? S_DRAIN : tmo_hit ? S_FILL : S_WAIT;
      S_DRAIN: state_d = mhs && last ? S_FILL : S_DRAIN;
      default: state_d = S_FILL;
    endcase
  end
  // datapath next values: word packing, slice counter, timeout, key, ciphertext shifter
  always_comb begin
    pt_d = pt_q;
    for (int i = 0; i < WORDS; i++)
      if (accept && cnt_q == CW'(i)) pt_d[DATA_WIDTH-1-i*WORD_WIDTH -: WORD_WIDTH] = s_data;
    cnt_d = accept || mhs ? (last ? '0 : cnt_q + CW'(1)) : cnt_q;
    tmo_d = state_q == S_WAIT && state_d == S_WAIT ? tmo_q + TW'(1) : '0;
    key_d = state_q == S_FILL && key_load ? key_in : key_q;
    ct_d  = state_q == S_WAIT && done_in ? ct_in : mhs ? ct_q << WORD_WIDTH : ct_q;
    err_d = err_q || tmo_hit;
  end
  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      tmo_q <= '0;
      pt_q  <= '0;
      key_q <= '0;
      ct_q  <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
      pt_q  <= pt_d;
      key_q <= key_d;
      ct_q  <= ct_d;
      err_q <= err_d;
    end
  end
  // outputs decoded from state; ciphertext leaves most-significant slice first
  always_comb begin
    s_ready     = state_q == S_FILL;
    start_out   = state_q == S_START;
    busy        = state_q != S_FILL;
    m_valid     = state_q == S_DRAIN;
    m_data      = ct_q[DATA_WIDTH-1 -: WORD_WIDTH];
    pt_out      = pt_q;
    key_out     = key_q;
    timeout_err = err_q;
  end
endmodule

// File: tb/tb_aes_stream_adapter.sv
// tb_aes_stream_adapter: directed FIPS-197 block tests with a scripted cipher-side responder
module tb_aes_stream_adapter;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic clk = 0, rst = 0, key_load = 0, s_valid = 0, done_in = 0, m_ready = 0;
  logic [127:0] key_in = KEY, ct_in = '0;
  logic [31:0] s_data = '0;
  logic s_ready, start_out, m_valid, busy, timeout_err;
  logic [127:0] pt_out, key_out;
  logic [31:0] m_data;
  int passed = 0, failed = 0, total = 0, nstart = 0, s0 = 0, idx = 0;

  aes_stream_adapter dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .pt_out(pt_out), .key_out(key_out), .start_out(start_out),
    .ct_in(ct_in), .done_in(done_in),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (start_out) nstart <= nstart + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic feed(input logic [127:0] pt, input int gap, input logic ld);
    for (int i = 0; i < 4; i++) begin
      s_valid = 1;
      s_data = pt[127-32*i -: 32];
      key_load = ld && i == 0;
      tick;
      s_valid = 0;
      key_load = 0;
      if (i < 3) repeat (gap) tick;
    end
  endtask

  task automatic cipher(input int lat, input string tag);
    tick;
    chk({tag, "_wait_nostart"}, start_out, 0);
    chk({tag, "_wait_busy"}, busy, 1);
    repeat (lat) tick;
    chk({tag, "_wait_novalid"}, m_valid, 0);
    done_in = 1;
    ct_in = CT;
    tick;
    done_in = 0;
    ct_in = '0;
  endtask

  task automatic drain(input string tag);
    m_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_valid%0d", tag, i), m_valid, 1);
      chk($sformatf("%s_word%0d", tag, i), m_data, CT[127-32*i -: 32]);
      tick;
    end
    chk({tag, "_done_novalid"}, m_valid, 0);
    chk({tag, "_done_fill"}, s_ready, 1);
    m_ready = 0;
  endtask

  initial begin
    rst = 1;
    tick;
    tick;
    rst = 0;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_start", start_out, 0);
    chk("rst_key", key_out, 0);
    chk("rst_pt", pt_out, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_err", timeout_err, 0);

    s0 = nstart;
    feed(PT, 0, 1);
    chk("fips_start", start_out, 1);
    chk("fips_pt", pt_out, PT);
    chk("fips_key", key_out, KEY);
    cipher(3, "fips");
    drain("fips");
    chk("fips_one_start", 128'(nstart - s0), 1);

    feed(PT, 0, 0);
    cipher(2, "bp");
    idx = 0;
    for (int c = 0; idx < 4 && c < 40; c++) begin
      m_ready = (c >= 4 && c < 14) ? 1'b0 : (c % 2 == 0);
      chk($sformatf("bp_valid_c%0d", c), m_valid, 1);
      chk($sformatf("bp_word_c%0d", c), m_data, CT[127-32*idx -: 32]);
      tick;
      if (m_ready) idx++;
    end
    m_ready = 0;
    chk("bp_all_words", 128'(idx), 4);
    chk("bp_end_novalid", m_valid, 0);
    chk("bp_end_fill", s_ready, 1);

    feed(PT, 3, 0);
    chk("gap_start", start_out, 1);
    chk("gap_pt", pt_out, PT);
    cipher(1, "gap");
    drain("gap");

    feed(~PT, 0, 0);
    chk("tmo_start", start_out, 1);
    repeat (64) tick;
    chk("tmo_still_busy", busy, 1);
    chk("tmo_not_yet", timeout_err, 0);
    tick;
    chk("tmo_err", timeout_err, 1);
    chk("tmo_s_ready", s_ready, 1);
    chk("tmo_idle", busy, 0);
    feed(PT, 0, 0);
    chk("tmo_next_pt", pt_out, PT);
    cipher(5, "post_tmo");
    drain("post_tmo");
    chk("tmo_err_sticky", timeout_err, 1);

    feed(PT, 0, 0);
    tick;
    key_in = '1;
    key_load = 1;
    tick;
    tick;
    chk("kp_key_held", key_out, KEY);
    key_load = 0;
    key_in = KEY;
    done_in = 1;
    ct_in = CT;
    tick;
    done_in = 0;
    ct_in = '0;
    drain("kp");
    chk("kp_key_after", key_out, KEY);

    feed(PT, 0, 0);
    tick;
    rst = 1;
    tick;
    rst = 0;
    tick;
    done_in = 1;
    ct_in = CT;
    tick;
    done_in = 0;
    ct_in = '0;
    chk("mr_m_valid", m_valid, 0);
    chk("mr_m_data", m_data, 0);
    chk("mr_busy", busy, 0);
    chk("mr_s_ready", s_ready, 1);
    chk("mr_key", key_out, 0);
    chk("mr_pt", pt_out, 0);
    chk("mr_err", timeout_err, 0);
    chk("mr_start", start_out, 0);
    tick;
    chk("mr_m_valid_later", m_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
